// File: rtl/rx_uart.sv
// rx_uart: UART receiver (start, WL data bits LSB first, even parity, stop) with valid/ready output.
// Ports:
//   CLK, RST             system clock, synchronous active-high reset
//   uart_rx              asynchronous serial line, idle high
//   data_rdy             consumer ready; word taken when data_vld && data_rdy
//   data_vld, rx_word    received word and its valid flag
//   parity_err           parity bit disagrees with XOR of data bits
//   frame_err            stop bit sampled low
//   overrun              one-cycle pulse when an unaccepted word is overwritten
module rx_uart #(
    parameter int WL        = 8,
    parameter int BAUD_RATE = 9600,
    parameter int CLK_FREQ  = 100000000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          uart_rx,
    input  logic          data_rdy,
    output logic          data_vld,
    output logic [WL-1:0] rx_word,
    output logic          parity_err,
    output logic          frame_err,
    output logic          overrun
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(WL + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [BW-1:0]   r_bits;
    logic            r_armed, w_armed_nx;
    logic [1:0]      r_sync;
    logic [WL-1:0]   r_sh;
    logic            r_par;
    logic            r_vld;
    logic [WL-1:0]   r_word;
    logic            r_perr;
    logic            r_ferr;
    logic            r_ovr;
    logic            w_rx, w_tc, w_shift, w_par_smp, w_done;

    assign w_rx = r_sync[1];
    // START waits half a bit to land mid-bit; every later bit waits a full bit.
    assign w_tc = (r_state == START) ? (r_cnt == CW'(HALF - 1)) : (r_cnt == CW'(CPB - 1));

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_armed_nx = r_armed;
        w_shift    = 1'b0;
        w_par_smp  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (w_rx) w_armed_nx = 1'b1;
                if (r_armed && !w_rx) w_state_nx = START;
            end
            START: if (w_tc) begin
                w_cnt_nx   = '0;
                w_state_nx = w_rx ? IDLE : DATA;
            end
            DATA: if (w_tc) begin
                w_cnt_nx = '0;
                w_shift  = 1'b1;
                if (r_bits == BW'(WL - 1)) w_state_nx = PARITY;
            end
            PARITY: if (w_tc) begin
                w_cnt_nx   = '0;
                w_par_smp  = 1'b1;
                w_state_nx = STOP;
            end
            STOP: if (w_tc) begin
                w_cnt_nx   = '0;
                w_done     = 1'b1;
                // A low stop bit (break) disarms start detection until the line is seen high.
                w_armed_nx = w_rx;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bits  <= '0;
            r_armed <= 1'b1;
            r_sync  <= 2'b11;
            r_sh    <= '0;
            r_par   <= 1'b0;
            r_vld   <= 1'b0;
            r_word  <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], uart_rx};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_armed <= w_armed_nx;
            if (r_state == START) r_bits <= '0;
            else if (w_shift) r_bits <= r_bits + 1'b1;
            if (w_shift) r_sh <= {w_rx, r_sh[WL-1:1]};
            if (w_par_smp) r_par <= w_rx;
            // Completing a frame alongside an acceptance is a clean handover, not an overrun.
            r_ovr <= w_done & r_vld & ~data_rdy;
            if (w_done) begin
                r_word <= r_sh;
                r_perr <= r_par ^ (^r_sh);
                r_ferr <= ~w_rx;
                r_vld  <= 1'b1;
            end else if (data_rdy) begin
                r_vld  <= 1'b0;
            end
        end
    end

    assign data_vld   = r_vld;
    assign rx_word    = r_word;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
endmodule
